// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that owns the write port of one shared WIDTH-bit register.
// Each owner keeps the grant for at most MAX_HOLD consecutive writes, then the grant rotates.
module reg_write_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NREQ-1:0]           req_i,
    input  logic [NREQ*WIDTH-1:0]     wdata_i,
    output logic [NREQ-1:0]           gnt_o,
    output logic [NREQ-1:0]           ack_o,
    output logic [$clog2(NREQ)-1:0]   owner_o,
    output logic                      busy_o,
    output logic [WIDTH-1:0]          q_o,
    output logic [WIDTH-1:0]          qbar_o
);

    localparam int unsigned OwnW  = $clog2(NREQ);
    localparam int unsigned HcntW = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   ack_q;
    logic [OwnW-1:0]   owner_q;
    logic              busy_q;
    logic [OwnW-1:0]   ptr_q;
    logic [HcntW-1:0]  hcnt_q;
    logic [WIDTH-1:0]  q_q;
    logic [WIDTH-1:0]  qbar_q;

    logic              idle_found;
    logic [OwnW-1:0]   idle_idx;
    logic [NREQ-1:0]   idle_oh;
    logic              rel_found;
    logic [OwnW-1:0]   rel_idx;
    logic [NREQ-1:0]   rel_oh;
    logic [OwnW-1:0]   rel_ptr;
    logic              wr;
    logic              hold_done;
    logic [WIDTH-1:0]  wr_data;
    int unsigned       scan_idle;
    int unsigned       scan_rel;

    // Two scans: one from the stored pointer (IDLE), one from owner+1 (release).
    always_comb begin
        rel_ptr    = (32'(owner_q) == NREQ - 1) ? '0 : owner_q + OwnW'(1);
        idle_found = 1'b0;
        idle_idx   = '0;
        rel_found  = 1'b0;
        rel_idx    = '0;
        scan_idle  = 0;
        scan_rel   = 0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            scan_idle = (32'(ptr_q) + j) % NREQ;
            scan_rel  = (32'(rel_ptr) + j) % NREQ;
            if (!idle_found && req_i[scan_idle]) begin
                idle_found = 1'b1;
                idle_idx   = OwnW'(scan_idle);
            end
            if (!rel_found && req_i[scan_rel]) begin
                rel_found = 1'b1;
                rel_idx   = OwnW'(scan_rel);
            end
        end
        idle_oh           = '0;
        idle_oh[idle_idx] = 1'b1;
        rel_oh            = '0;
        rel_oh[rel_idx]   = 1'b1;
    end

    always_comb begin
        wr        = req_i[owner_q];
        wr_data   = wdata_i[32'(owner_q) * WIDTH +: WIDTH];
        hold_done = (32'(hcnt_q) + 32'd1) == MAX_HOLD;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ack_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            hcnt_q  <= '0;
            q_q     <= '0;
            qbar_q  <= '1;
        end else begin
            ack_q <= '0;
            case (state_q)
                StIdle: begin
                    if (idle_found) begin
                        state_q <= StOwn;
                        busy_q  <= 1'b1;
                        gnt_q   <= idle_oh;
                        owner_q <= idle_idx;
                        hcnt_q  <= '0;
                    end
                end
                StOwn: begin
                    if (wr) begin
                        q_q    <= wr_data;
                        qbar_q <= ~wr_data;
                        ack_q  <= gnt_q;
                        hcnt_q <= hcnt_q + HcntW'(1);
                    end
                    // Release re-arbitrates in the same edge so there is no idle bubble.
                    if (!wr || hold_done) begin
                        ptr_q  <= rel_ptr;
                        hcnt_q <= '0;
                        if (rel_found) begin
                            gnt_q   <= rel_oh;
                            owner_q <= rel_idx;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            gnt_q   <= '0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gnt_o   = gnt_q;
    assign ack_o   = ack_q;
    assign owner_o = owner_q;
    assign busy_o  = busy_q;
    assign q_o     = q_q;
    assign qbar_o  = qbar_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus randomized traffic against
// a behavioural model of owner, rotation pointer and register contents.
module tb_reg_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   gnt, ack;
    logic [1:0]     owner;
    logic           busy;
    logic [W-1:0]   q, qbar;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int           m_busy = 0;
    int           m_owner = 0;
    int           m_ptr = 0;
    int           m_cnt = 0;
    int           m_ack = -1;
    logic [W-1:0] m_q = '0;

    reg_write_arbiter #(.NREQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .req_i   (req),
        .wdata_i (wdata),
        .gnt_o   (gnt),
        .ack_o   (ack),
        .owner_o (owner),
        .busy_o  (busy),
        .q_o     (q),
        .qbar_o  (qbar)
    );

    always #5 clk = ~clk;

    function automatic int pick(int p, logic [N-1:0] r);
        for (int j = 0; j < N; j++) begin
            if (r[(p + j) % N]) return (p + j) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        int k;
        bit released;
        m_ack = -1;
        if (reset) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_q = '0;
        end else if (m_busy == 0) begin
            w = pick(m_ptr, req);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_cnt = 0;
            end
        end else begin
            k = m_owner;
            released = 1'b1;
            if (req[k]) begin
                m_q   = wdata[k*W +: W];
                m_ack = k;
                m_cnt = m_cnt + 1;
                released = (m_cnt == MH);
            end
            if (released) begin
                m_ptr = (k + 1) % N;
                m_cnt = 0;
                w = pick(m_ptr, req);
                if (w >= 0) m_owner = w;
                else m_busy = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [N-1:0] want_ack;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req = N'($urandom);
            wdata = $urandom;
            tick();
        end
        n_checks++;
        if (q !== 8'h00 || qbar !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_q: q=%h qbar=%h, required 00/FF", q, qbar);
        end
        n_checks++;
        if (gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: gnt=%b ack=%b busy=%b, required 0000/0000/0", gnt, ack, busy);
        end
        reset = 1'b0;
        req = 4'b0001;
        wdata = 32'h0000_0033;
        tick();
        tick();
        want_ack = 4'b0001;
        n_checks++;
        if (ack !== want_ack || q !== 8'h33) begin
            n_fail++;
            $display("FAIL reset_prewrite: ack=%b q=%h, required %b/33", ack, q, want_ack);
        end
        // Reset lands while owner 0 would write again.
        reset = 1'b1;
        wdata = 32'h0000_0077;
        tick();
        n_checks++;
        if (q !== 8'h00 || qbar !== 8'hFF || gnt !== 4'b0000 || ack !== 4'b0000 ||
            busy !== 1'b0 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_midwrite: q=%h qbar=%h gnt=%b ack=%b busy=%b owner=%0d, required reset values",
                     q, qbar, gnt, ack, busy, owner);
        end
        reset = 1'b0;
        req = '0;
        tick();
    endtask

    task automatic test_single_write();
        do_reset();
        req = 4'b0100;
        wdata = 32'h00A5_0000;
        tick();
        n_checks++;
        if (gnt !== 4'b0100 || busy !== 1'b1 || owner !== 2'd2 || ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%b busy=%b owner=%0d ack=%b, required 0100/1/2/0000",
                     gnt, busy, owner, ack);
        end
        tick();
        n_checks++;
        if (q !== 8'hA5 || qbar !== 8'h5A || ack !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_write: q=%h qbar=%h ack=%b, required A5/5A/0100", q, qbar, ack);
        end
        req = '0;
        tick();
        n_checks++;
        if (gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0 || q !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_release: gnt=%b ack=%b busy=%b q=%h, required 0000/0000/0/A5",
                     gnt, ack, busy, q);
        end
    endtask

    task automatic test_rotation();
        int bad;
        int o;
        do_reset();
        req = 4'b1111;
        wdata = 32'h4433_2211;
        tick();
        bad = 0;
        for (int w = 0; w < 4 * MH; w++) begin
            o = w / MH;
            if (owner !== 2'(o)) bad++;
            tick();
            if (ack !== 4'(1 << o) || q !== 8'(8'h11 * (o + 1))) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rotation_seq: %0d bad cycles, required 0", bad);
        end
        n_checks++;
        if (owner !== 2'd0 || gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL rotation_wrap: owner=%0d gnt=%b, required 0/0001", owner, gnt);
        end
        req = '0;
        tick();
    endtask

    task automatic test_early_release();
        do_reset();
        req = 4'b0010;
        wdata = 32'hD0C0_B1A0;
        tick();
        req = 4'b1010;
        tick();
        wdata = 32'hD0C0_B2A0;
        tick();
        n_checks++;
        if (q !== 8'hB2 || ack !== 4'b0010 || gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL early_two_writes: q=%h ack=%b gnt=%b, required B2/0010/0010", q, ack, gnt);
        end
        req = 4'b1000;
        wdata = 32'hD0C0_B3A0;
        tick();
        n_checks++;
        if (gnt !== 4'b1000 || ack !== 4'b0000 || q !== 8'hB2) begin
            n_fail++;
            $display("FAIL early_drop: gnt=%b ack=%b q=%h, required 1000/0000/B2", gnt, ack, q);
        end
        tick();
        n_checks++;
        if (ack !== 4'b1000 || q !== 8'hD0) begin
            n_fail++;
            $display("FAIL early_next_write: ack=%b q=%h, required 1000/D0", ack, q);
        end
        req = '0;
        tick();
    endtask

    task automatic test_pointer_priority();
        do_reset();
        req = 4'b0100;
        wdata = 32'h3333_2222;
        tick();
        tick();
        req = '0;
        tick();
        req = 4'b1010;
        tick();
        n_checks++;
        if (gnt !== 4'b1000 || owner !== 2'd3) begin
            n_fail++;
            $display("FAIL prio_first: gnt=%b owner=%0d, required 1000/3", gnt, owner);
        end
        tick();
        req = 4'b0010;
        tick();
        n_checks++;
        if (gnt !== 4'b0010 || owner !== 2'd1 || ack !== 4'b0000 || q !== 8'h33) begin
            n_fail++;
            $display("FAIL prio_second: gnt=%b owner=%0d ack=%b q=%h, required 0010/1/0000/33",
                     gnt, owner, ack, q);
        end
        req = '0;
        tick();
    endtask

    task automatic test_sole_requester();
        int writes;
        int gaps;
        logic [W-1:0] d;
        do_reset();
        req = 4'b0001;
        tick();
        writes = 0;
        gaps = 0;
        for (int i = 0; i < 10; i++) begin
            d = W'($urandom);
            wdata = {24'($urandom), d};
            tick();
            if (ack === 4'b0001 && q === d && qbar === ~d) writes++;
            if (gnt !== 4'b0001) gaps++;
        end
        n_checks++;
        if (writes != 10) begin
            n_fail++;
            $display("FAIL sole_writes: %0d writes, required 10", writes);
        end
        n_checks++;
        if (gaps != 0) begin
            n_fail++;
            $display("FAIL sole_gnt: %0d cycles with gnt[0] low, required 0", gaps);
        end
        req = '0;
        tick();
    endtask

    task automatic test_random();
        int bad;
        logic [N-1:0] m_gnt;
        logic [N-1:0] m_ackv;
        bad = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            wdata = $urandom;
            reset = ($urandom_range(0, 49) == 0);
            tick();
            m_gnt  = (m_busy != 0) ? N'(1 << m_owner) : '0;
            m_ackv = (m_ack >= 0) ? N'(1 << m_ack) : '0;
            n_checks++;
            if (gnt !== m_gnt || ack !== m_ackv || busy !== (m_busy != 0) ||
                q !== m_q || qbar !== ~m_q || (m_busy != 0 && owner !== 2'(m_owner))) begin
                n_fail++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_cycle %0d: gnt=%b ack=%b busy=%b owner=%0d q=%h qbar=%h, required gnt=%b ack=%b busy=%0d owner=%0d q=%h",
                             i, gnt, ack, busy, owner, q, qbar, m_gnt, m_ackv, m_busy, m_owner, m_q);
            end
        end
        reset = 1'b0;
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_rotation();
        test_early_release();
        test_pointer_priority();
        test_sole_requester();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter that shares one WIDTH-bit storage register (a bank of D flip-flops with true and complement outputs) among NREQ requesters. A requester holds write ownership for up to MAX_HOLD consecutive writes before ownership is forcibly rotated. The block sits between the requesters and the shared register and owns the register's write enable and data mux.

## Interface
- NREQ, 4: number of requesters (2..8)
- WIDTH, 8: shared register width
- MAX_HOLD, 4: maximum consecutive writes per ownership (>=1)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  request per requester; level, held while it wants to write
- wdata  in  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot (or zero) registered grant
- ack  out  NREQ  one-cycle pulse per completed write, to the writing requester
- owner  out  clog2(NREQ)  index of the current owner (valid when busy=1)
- busy  out  1  1 while state = OWN
- q  out  WIDTH  shared register contents
- qbar  out  WIDTH  bitwise complement of q, registered alongside q

## Operation
- States: IDLE, OWN. Internal: round-robin pointer ptr (clog2(NREQ) bits), hold counter hcnt (0..MAX_HOLD).
- Arbitration: the winner is the first i with req[i]=1, scanning ptr, ptr+1, ... modulo NREQ.
- IDLE: if any req is 1 at the edge, go to OWN, gnt <= onehot(winner), owner <= winner, hcnt <= 0. Otherwise stay IDLE with gnt=0.
- OWN with owner k, at each edge:
  - Write when req[k]=1: q <= wdata slice k, qbar <= ~slice k, ack[k] <= 1, hcnt <= hcnt+1.
  - No write (req[k]=0): q and qbar hold, and ack is 0.
  - Release happens when req[k]=0, or when this write brings hcnt to MAX_HOLD.
  - On release: ptr <= k+1 mod NREQ, then arbitrate immediately using that new ptr over the current req vector. If a winner exists, stay in OWN, gnt <= onehot(winner), hcnt <= 0, with no idle bubble. If there is none, go to IDLE and gnt <= 0.
  - Requester k may win again on release if it is the only one requesting. gnt[k] then stays high continuously.
- Only the granted requester can write. req/wdata from non-owners are ignored.
- ack is 0 whenever no write happened at the previous edge. At most one ack bit is high at a time.

## Timing
- Reset (synchronous, highest priority): state=IDLE, gnt=0, ack=0, owner=0, busy=0, ptr=0, hcnt=0, q=0, qbar=all ones.
- A reset coincident with an in-progress write discards the write. q is 0 after that edge.
- Latency:
  - req[i] rises before edge E0 (state IDLE): gnt[i]=1 after E0.
  - First write at E1: q, qbar and ack[i] are updated after E1.
  - Request to data is 2 edges. Sustained req gives one write per cycle.
- With MAX_HOLD writes at edges E1..E(MAX_HOLD), the grant moves to the next requester after E(MAX_HOLD). Its first write happens at E(MAX_HOLD+1).
- A requester dropping req loses the grant at the next edge. No write or ack occurs for that edge.
- gnt, owner and busy change only on clock edges and are glitch-free registered outputs.

## Test plan
- Reset check: hold reset 2 cycles with random req/wdata. Required: q=0x00, qbar=0xFF, gnt=0, ack=0, busy=0. Then assert reset while OWN and mid-write. Required: all outputs return to reset values after that edge.
- Single write: req[2]=1, wdata slice 2=0xA5, from IDLE. Required: gnt=4'b0100 after E0; q=0xA5, qbar=0x5A, ack=4'b0100 after E1.
- Forced rotation: all four req high continuously, distinct data per requester, MAX_HOLD=4. Required: owner sequence 0,1,2,3,0, each holding exactly 4 consecutive writes. No cycle without a write after the first grant.
- Early release: owner 1 drops req after 2 writes while req[3]=1. Required: gnt moves to 4'b1000 at the drop edge, with no ack that cycle, and q holds the second write's value.
- Pointer priority: after owner 2 releases, req[1] and req[3] rise together. Required: grant goes to 3, then after its release to 1.
- Sole requester: only req[0] high for 10 cycles. Required: 10 writes and 10 acks, with gnt[0] continuously high across the MAX_HOLD boundary.
